// File: rtl/series_approx_unit.sv
`default_nettype none
// ============================================================================
// Module      : series_approx_unit
// Description : Self-sequencing truncated geometric series y = sum d^k,
//               d = 1-x (mode 0) or x-1 (mode 1), with saturating result.
//               Optional early exit on a zero term: SERIES_EARLY_TERM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module series_approx_unit #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 7,
    parameter int IT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [IT_W-1:0]   numIt_i,
    input  logic              mode_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] y_o,
    output logic              sat_o,
    output logic [IT_W-1:0]   it_used_o
);

    localparam int c_TW = DATA_W + 2;
    localparam int c_AW = DATA_W + 3;
    localparam int c_PW = 2 * c_TW;
    localparam logic signed [c_TW-1:0] c_one = c_TW'(2 ** FRAC_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [DATA_W-1:0]        r_x;
    logic [IT_W-1:0]          r_n;
    logic                     r_mode;
    logic signed [c_TW-1:0]   r_d;
    logic signed [c_TW-1:0]   r_term;
    logic signed [c_AW-1:0]   r_acc;
    logic [IT_W-1:0]          r_cnt;
    logic [DATA_W-1:0]        r_y;
    logic                     r_sat;
    logic [IT_W-1:0]          r_it;
    logic                     r_valid;

    logic signed [c_TW-1:0]   w_x_ext;
    logic signed [c_TW-1:0]   w_d_load;
    logic signed [c_PW-1:0]   w_prod;
    logic signed [c_TW-1:0]   w_term_next;
    logic signed [c_AW-1:0]   w_acc_sum;
    logic [IT_W:0]            w_cnt_inc;
    logic                     w_last;
    logic                     w_stop;
    logic [DATA_W-1:0]        w_y_clamp;
    logic                     w_sat;

    assign w_x_ext     = $signed({2'b00, r_x});
    assign w_d_load    = r_mode ? (w_x_ext - c_one) : (c_one - w_x_ext);
    assign w_prod      = c_PW'(r_term) * c_PW'(r_d);
    // Arithmetic shift floors negative products toward minus infinity.
    assign w_term_next = c_TW'(w_prod >>> FRAC_W);
    assign w_acc_sum   = r_acc + c_AW'(r_term);
    assign w_cnt_inc   = {1'b0, r_cnt} + 1'b1;
    assign w_last      = (w_cnt_inc == {1'b0, r_n});

`ifdef SERIES_EARLY_TERM_EN
    // A zero term keeps every later term zero, so the sum is final.
    assign w_stop = w_last || (r_term == '0);
`else
    assign w_stop = w_last;
`endif

    always_comb begin
        w_y_clamp = r_acc[DATA_W-1:0];
        w_sat     = 1'b0;
        if (r_acc[c_AW-1]) begin
            w_y_clamp = '0;
            w_sat     = 1'b1;
        end else if (r_acc[c_AW-2:DATA_W] != '0) begin
            w_y_clamp = '1;
            w_sat     = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next_state = S_LOAD;
            S_LOAD: w_next_state = (r_n == '0) ? S_DONE : S_MUL;
            S_MUL:  w_next_state = S_ACC;
            S_ACC:  w_next_state = w_stop ? S_DONE : S_MUL;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_n     <= '0;
            r_mode  <= 1'b0;
            r_d     <= '0;
            r_term  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_sat   <= 1'b0;
            r_it    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_x    <= x_i;
                        r_n    <= numIt_i;
                        r_mode <= mode_i;
                    end
                end
                S_LOAD: begin
                    r_d    <= w_d_load;
                    r_term <= c_one;
                    r_acc  <= c_AW'(c_one);
                    r_cnt  <= '0;
                end
                S_MUL: r_term <= w_term_next;
                S_ACC: begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_inc[IT_W-1:0];
                end
                S_DONE: begin
                    r_y   <= w_y_clamp;
                    r_sat <= w_sat;
                    r_it  <= r_cnt;
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign valid_o   = r_valid;
    assign y_o       = r_y;
    assign sat_o     = r_sat;
    assign it_used_o = r_it;

endmodule
`default_nettype wire

// File: tb/tb_series_approx_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_series_approx_unit
// Description : Directed vector bench for series_approx_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_series_approx_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] x_i = '0;
    logic [2:0] numIt_i = '0;
    logic       mode_i = 1'b0;
    logic       busy_o;
    logic       valid_o;
    logic [7:0] y_o;
    logic       sat_o;
    logic [2:0] it_used_o;

    int checks = 0;
    int failures = 0;

    series_approx_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .x_i       (x_i),
        .numIt_i   (numIt_i),
        .mode_i    (mode_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .y_o       (y_o),
        .sat_o     (sat_o),
        .it_used_o (it_used_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [2:0] n;
        logic       mode;
        logic [7:0] y;
        logic       sat;
        logic [2:0] it;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [7:0] x, input logic [2:0] n, input logic m,
                       output int lat, output logic seen);
        x_i     = x;
        numIt_i = n;
        mode_i  = m;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_after_start", int'(busy_o), 1);
        chk("valid_is_pulse", int'(valid_o), 0);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (valid_o) seen = 1'b1;
        end
        chk("valid_seen", int'(seen), 1);
    endtask

    initial begin
        int   lat;
        logic seen;
        int   nvalid;
        int   first_lat;
        logic [7:0] y_cap;

        vecs[0]  = '{8'd96,  3'd3, 1'b0, 8'd170, 1'b0, 3'd3, 8};
        vecs[1]  = '{8'd224, 3'd1, 1'b0, 8'd32,  1'b0, 3'd1, 4};
        vecs[2]  = '{8'd224, 3'd2, 1'b0, 8'd104, 1'b0, 3'd2, 6};
        vecs[3]  = '{8'd192, 3'd7, 1'b1, 8'd255, 1'b0, 3'd7, 16};
        vecs[4]  = '{8'd224, 3'd7, 1'b1, 8'd255, 1'b1, 3'd7, 16};
        vecs[5]  = '{8'd77,  3'd0, 1'b1, 8'd128, 1'b0, 3'd0, 2};
        vecs[6]  = '{8'd0,   3'd1, 1'b0, 8'd255, 1'b1, 3'd1, 4};
        vecs[7]  = '{8'd255, 3'd1, 1'b1, 8'd255, 1'b0, 3'd1, 4};
        vecs[8]  = '{8'd200, 3'd3, 1'b0, 8'd73,  1'b0, 3'd3, 8};
`ifdef SERIES_EARLY_TERM_EN
        vecs[9]  = '{8'd128, 3'd7, 1'b0, 8'd128, 1'b0, 3'd1, 4};
        vecs[10] = '{8'd96,  3'd7, 1'b0, 8'd170, 1'b0, 3'd4, 10};
`else
        vecs[9]  = '{8'd128, 3'd7, 1'b0, 8'd128, 1'b0, 3'd7, 16};
        vecs[10] = '{8'd96,  3'd7, 1'b0, 8'd170, 1'b0, 3'd7, 16};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_y", int'(y_o), 0);
        chk("rst_sat", int'(sat_o), 0);
        chk("rst_it", int'(it_used_o), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Consecutive vectors start in the valid cycle: back-to-back acceptance.
        for (int v = 0; v < 11; v++) begin
            run(vecs[v].x, vecs[v].n, vecs[v].mode, lat, seen);
            chk($sformatf("v%0d_lat", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_y", v), int'(y_o), int'(vecs[v].y));
            chk($sformatf("v%0d_sat", v), int'(sat_o), int'(vecs[v].sat));
            chk($sformatf("v%0d_it", v), int'(it_used_o), int'(vecs[v].it));
        end

        // start_i pulsed while busy must be ignored.
        @(posedge clk);
        #1;
        x_i = 8'd96; numIt_i = 3'd3; mode_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        nvalid = 0; first_lat = 0; y_cap = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 2) begin
                x_i = 8'd0; numIt_i = 3'd7; mode_i = 1'b1; start_i = 1'b1;
            end
            @(posedge clk);
            #1;
            start_i = 1'b0;
            if (valid_o) begin
                nvalid++;
                if (nvalid == 1) begin
                    first_lat = i;
                    y_cap     = y_o;
                end
            end
        end
        chk("busy_start_valid_count", nvalid, 1);
        chk("busy_start_lat", first_lat, 8);
        chk("busy_start_y", int'(y_cap), 170);

        // Reset in the middle of a computation aborts it.
        x_i = 8'd224; numIt_i = 3'd7; mode_i = 1'b1; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_valid", int'(valid_o), 0);
        chk("midrst_y", int'(y_o), 0);
        chk("midrst_sat", int'(sat_o), 0);
        chk("midrst_it", int'(it_used_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (valid_o || busy_o) nvalid++;
        end
        chk("midrst_no_activity", nvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
